// File: rtl/regfile_arb_pkg.sv
// Shared defaults and arbiter state type for the register-file write arbiter.
package regfile_arb_pkg;

  localparam int unsigned DATA_W_DEF     = 32;
  localparam int unsigned ADDR_W_DEF     = 5;
  localparam int unsigned FIFO_DEPTH_DEF = 2;

  // Names the requester that received the most recent grant.
  typedef enum logic {
    LAST_ALU = 1'b0,
    LAST_MEM = 1'b1
  } arb_ptr_e;

endpackage

// File: rtl/wb_fifo.sv
// Writeback queue: holds {addr, data} entries for one requester and reports
// whether either decode source address matches a queued entry.
module wb_fifo #(
  parameter  int unsigned DATA_W = 32,
  parameter  int unsigned ADDR_W = 5,
  parameter  int unsigned DEPTH  = 2,
  localparam int unsigned PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              push_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              pop_i,
  output logic [ADDR_W-1:0] head_addr_o,
  output logic [DATA_W-1:0] head_data_o,
  output logic [CNT_W-1:0]  count_o,
  output logic              full_o,
  output logic              empty_o,
  input  logic [ADDR_W-1:0] rs_addr_i,
  input  logic [ADDR_W-1:0] rt_addr_i,
  output logic              rs_hit_o,
  output logic              rt_hit_o
);

  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              do_push, do_pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full_o      = (count_q == CNT_W'(DEPTH));
  assign empty_o     = (count_q == '0);
  assign count_o     = count_q;
  assign head_addr_o = addr_q[rd_ptr_q];
  assign head_data_o = data_q[rd_ptr_q];

  // Flush wins over both push and pop, so a write arriving on the flush edge is dropped.
  assign do_push = push_i && !full_o  && !flush_i;
  assign do_pop  = pop_i  && !empty_o && !flush_i;

  // Next pointer/count state; push and pop together leave the count unchanged.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = next_ptr(wr_ptr_q);
      if (do_pop)  rd_ptr_d = next_ptr(rd_ptr_q);
      if (do_push && !do_pop)      count_d = count_q + 1'b1;
      else if (do_pop && !do_push) count_d = count_q - 1'b1;
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; contents are only meaningful inside the occupied window.
  always_ff @(posedge clk_i) begin
    if (do_push) begin
      addr_q[wr_ptr_q] <= addr_i;
      data_q[wr_ptr_q] <= data_i;
    end
  end

  // Source-address match against occupied entries only (offset from head < count).
  always_comb begin
    int unsigned offs;
    offs     = 0;
    rs_hit_o = 1'b0;
    rt_hit_o = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      offs = (i + DEPTH - 32'(rd_ptr_q)) % DEPTH;
      if (offs < 32'(count_q)) begin
        if (addr_q[PTR_W'(i)] == rs_addr_i) rs_hit_o = 1'b1;
        if (addr_q[PTR_W'(i)] == rt_addr_i) rt_hit_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Merges ALU and load writebacks into the single register-file write port,
// round-robin on contention, and flags decode sources with writes in flight.
module regfile_write_arbiter
  import regfile_arb_pkg::*;
#(
  parameter int unsigned DATA_W     = DATA_W_DEF,
  parameter int unsigned ADDR_W     = ADDR_W_DEF,
  parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              alu_valid,
  input  logic [ADDR_W-1:0] alu_addr,
  input  logic [DATA_W-1:0] alu_data,
  output logic              alu_ready,
  input  logic              mem_valid,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_data,
  output logic              mem_ready,
  input  logic              flush,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic [ADDR_W-1:0] rt_addr,
  output logic              rs_pending,
  output logic              rt_pending
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

  logic [ADDR_W-1:0] alu_head_addr, mem_head_addr;
  logic [DATA_W-1:0] alu_head_data, mem_head_data;
  logic [CNT_W-1:0]  alu_count, mem_count;
  logic              alu_full, mem_full, alu_empty, mem_empty;
  logic              alu_rs_hit, alu_rt_hit, mem_rs_hit, mem_rt_hit;
  logic              grant_alu, grant_mem;

  arb_ptr_e          ptr_q;
  logic              wr_en_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [DATA_W-1:0] wr_data_q;

  assign alu_ready = (alu_count < CNT_W'(FIFO_DEPTH));
  assign mem_ready = (mem_count < CNT_W'(FIFO_DEPTH));

  // Alternate on contention: the requester not named by the pointer wins.
  assign grant_alu = !alu_empty && (mem_empty || ptr_q == LAST_MEM);
  assign grant_mem = !mem_empty && (alu_empty || ptr_q == LAST_ALU);

  wb_fifo #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(FIFO_DEPTH)) u_alu_fifo (
    .clk_i       (clock),
    .rst_i       (reset),
    .flush_i     (flush),
    .push_i      (alu_valid && !alu_full),
    .addr_i      (alu_addr),
    .data_i      (alu_data),
    .pop_i       (grant_alu),
    .head_addr_o (alu_head_addr),
    .head_data_o (alu_head_data),
    .count_o     (alu_count),
    .full_o      (alu_full),
    .empty_o     (alu_empty),
    .rs_addr_i   (rs_addr),
    .rt_addr_i   (rt_addr),
    .rs_hit_o    (alu_rs_hit),
    .rt_hit_o    (alu_rt_hit)
  );

  wb_fifo #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(FIFO_DEPTH)) u_mem_fifo (
    .clk_i       (clock),
    .rst_i       (reset),
    .flush_i     (flush),
    .push_i      (mem_valid && !mem_full),
    .addr_i      (mem_addr),
    .data_i      (mem_data),
    .pop_i       (grant_mem),
    .head_addr_o (mem_head_addr),
    .head_data_o (mem_head_data),
    .count_o     (mem_count),
    .full_o      (mem_full),
    .empty_o     (mem_empty),
    .rs_addr_i   (rs_addr),
    .rt_addr_i   (rt_addr),
    .rs_hit_o    (mem_rs_hit),
    .rt_hit_o    (mem_rt_hit)
  );

  // Arbiter pointer and registered write port; flush suppresses the grant.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ptr_q     <= LAST_MEM;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else if (flush) begin
      wr_en_q   <= 1'b0;
    end else if (grant_alu) begin
      ptr_q     <= LAST_ALU;
      wr_en_q   <= 1'b1;
      wr_addr_q <= alu_head_addr;
      wr_data_q <= alu_head_data;
    end else if (grant_mem) begin
      ptr_q     <= LAST_MEM;
      wr_en_q   <= 1'b1;
      wr_addr_q <= mem_head_addr;
      wr_data_q <= mem_head_data;
    end else begin
      wr_en_q   <= 1'b0;
    end
  end

  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;

  assign rs_pending = alu_rs_hit | mem_rs_hit | (wr_en_q && (wr_addr_q == rs_addr));
  assign rt_pending = alu_rt_hit | mem_rt_hit | (wr_en_q && (wr_addr_q == rt_addr));

endmodule
